// File: rtl/inv_sbox_iter.sv
// Iterative AES inverse S-box: inverse affine, then GF(2^8) inversion as x^254 by square-and-multiply.
// Optional INV_SBOX_FWD_EN adds a fwd port selecting the forward S-box (inversion followed by affine 0x63).
module inv_sbox_iter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
`ifdef INV_SBOX_FWD_EN
    input  logic       fwd,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [DATA_W-1:0] INV_AFF_C = 8'h05;
    localparam logic [DATA_W-1:0] FWD_AFF_C = 8'h63;
    localparam logic [DATA_W-1:0] GF_RED    = 8'h1B;
    localparam logic [DATA_W-1:0] GF_ONE    = 8'h01;
    localparam logic [CNT_W-1:0]  LAST_STEP = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Shift-and-add GF(2^8) product, reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [DATA_W-1:0] gf_mul(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] aa;
        logic [DATA_W-1:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? GF_RED : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // b[i] = a[i+2] ^ a[i+5] ^ a[i+7] ^ c[i] (indices mod 8).
    function automatic logic [DATA_W-1:0] inv_affine(input logic [DATA_W-1:0] a);
        return {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ INV_AFF_C;
    endfunction

`ifdef INV_SBOX_FWD_EN
    // b[i] = a[i] ^ a[i+4] ^ a[i+5] ^ a[i+6] ^ a[i+7] ^ c[i] (indices mod 8).
    function automatic logic [DATA_W-1:0] fwd_affine(input logic [DATA_W-1:0] a);
        return a ^ {a[3:0], a[7:4]} ^ {a[4:0], a[7:5]} ^ {a[5:0], a[7:6]}
                 ^ {a[6:0], a[7]} ^ FWD_AFF_C;
    endfunction
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] sq_q, sq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] x_c;
    logic [DATA_W-1:0] sq_in_c;
    logic [DATA_W-1:0] sq_sq_c;
    logic [DATA_W-1:0] prod_c;
    logic [DATA_W-1:0] result_c;

`ifdef INV_SBOX_FWD_EN
    logic              fwd_q, fwd_d;

    assign x_c      = fwd ? in_data : inv_affine(in_data);
    assign result_c = fwd_q ? fwd_affine(prod_c) : prod_c;
`else
    assign x_c      = inv_affine(in_data);
    assign result_c = prod_c;
`endif

    // One squarer serves both the initial x*x in IDLE and the per-step sq*sq in CALC.
    assign sq_in_c = (state_q == S_IDLE) ? x_c : sq_q;
    assign sq_sq_c = gf_mul(sq_in_c, sq_in_c);
    assign prod_c  = gf_mul(acc_q, sq_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sq_d    = sq_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
`ifdef INV_SBOX_FWD_EN
        fwd_d   = fwd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    acc_d   = GF_ONE;
                    sq_d    = sq_sq_c;
                    cnt_d   = '0;
`ifdef INV_SBOX_FWD_EN
                    fwd_d   = fwd;
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = prod_c;
                sq_d  = sq_sq_c;
                cnt_d = cnt_q + 3'd1;
                // After six steps acc = x^126 and sq = x^128, so acc*sq = x^254.
                if (cnt_q == LAST_STEP) begin
                    out_d   = result_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            sq_q        <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sq_q        <= sq_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef INV_SBOX_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= 1'b0;
        end else begin
            fwd_q <= fwd_d;
        end
    end
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_inv_sbox_iter.sv
// Self-checking bench for inv_sbox_iter: vector table, exhaustive sweep, random scoreboard, corner sequences.
module tb_inv_sbox_iter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       fwd;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int checks;
    int errors;

    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t[256];

    typedef struct {
        logic [7:0] din;
        logic       f;
        logic [7:0] exp;
    } vec_t;

    inv_sbox_iter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
`ifdef INV_SBOX_FWD_EN
        .fwd      (fwd),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain polynomial product mod 0x11B for building the reference tables.
    function automatic int gmul(input int a, input int b);
        int p;
        int aa;
        p  = 0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 256) != 0) aa = aa ^ 32'h11B;
        end
        return p;
    endfunction

    function automatic int rotl8(input int v, input int k);
        return ((v << k) | (v >> (8 - k))) & 255;
    endfunction

    // S-box = affine(inverse by exhaustive search); InvSbox is its table inverse.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            int inv;
            int s;
            inv = 0;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, y) == 1) inv = y;
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 32'h63;
            sbox_t[x] = 8'(s);
        end
        for (int x = 0; x < 256; x++) begin
            isbox_t[sbox_t[x]] = 8'(x);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic f);
        return f ? sbox_t[d] : isbox_t[d];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call from IDLE with out_ready high; returns in IDLE after the result is consumed.
    task automatic run_one(input string name, input logic [7:0] d, input logic f,
                           input logic [7:0] exp);
        int k;
        chk({name, " in_ready before accept"}, 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        fwd      = f;
        tick();
        in_valid = 1'b0;
        in_data  = 8'(~d);
        fwd      = ~f;
        chk({name, " in_ready after accept"}, 32'(in_ready), 0);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({name, " latency"}, k, 7);
        chk({name, " data"}, 32'(out_data), 32'(exp));
        tick();
        chk({name, " consumed"}, 32'(out_valid), 0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        logic [7:0] exp_q[$];
        logic       seen_valid;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        fwd       = 1'b0;
        out_ready = 1'b1;
        build_tables();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_data", 32'(out_data), 0);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (4) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("no spurious out_valid", 32'(seen_valid), 0);

        // Known vectors
        v.f = 1'b0;
        v.din = 8'h63; v.exp = 8'h00; vecs.push_back(v);
        v.din = 8'h7C; v.exp = 8'h01; vecs.push_back(v);
        v.din = 8'h00; v.exp = 8'h52; vecs.push_back(v);
        v.din = 8'h16; v.exp = 8'hFF; vecs.push_back(v);
        v.din = 8'hED; v.exp = 8'h53; vecs.push_back(v);
`ifdef INV_SBOX_FWD_EN
        v.f = 1'b1;
        v.din = 8'h00; v.exp = 8'h63; vecs.push_back(v);
        v.din = 8'h01; v.exp = 8'h7C; vecs.push_back(v);
        v.din = 8'h53; v.exp = 8'hED; vecs.push_back(v);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].din, vecs[i].f, vecs[i].exp);
        end

        // Exhaustive back-to-back sweep with spacing check
        begin
            int idx;
            int cyc;
            int last_acc;
            int got;
            logic acc_now;
            idx      = 0;
            cyc      = 0;
            last_acc = -1;
            got      = 0;
            fwd      = 1'b0;
            in_valid = 1'b1;
            in_data  = 8'h00;
            while (got < 256 && cyc < 256 * 9 + 50) begin
                acc_now = in_ready && in_valid;
                if (out_valid) begin
                    chk($sformatf("sweep out 0x%02h", got), 32'(out_data), 32'(exp_q.pop_front()));
                    got++;
                end
                if (acc_now) begin
                    exp_q.push_back(model(in_data, 1'b0));
                    if (last_acc >= 0) chk("sweep accept spacing", cyc - last_acc, 9);
                    last_acc = cyc;
                end
                tick();
                cyc++;
                if (acc_now) begin
                    idx++;
                    if (idx < 256) in_data = 8'(idx);
                    else in_valid = 1'b0;
                end
            end
            chk("sweep results received", got, 256);
            exp_q.delete();
        end
        tick();

        // Randomized traffic with backpressure against the scoreboard
        begin
            int n_acc;
            n_acc = 0;
            for (int c = 0; c < 3000; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = 8'($urandom_range(0, 255));
`ifdef INV_SBOX_FWD_EN
                fwd       = 1'($urandom_range(0, 1));
`endif
                out_ready = ($urandom_range(0, 2) != 0);
                if (in_ready && in_valid) begin
                    exp_q.push_back(model(in_data, fwd));
                    n_acc++;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) chk("rand unexpected out_valid", 1, 0);
                    else chk("rand out_data", 32'(out_data), 32'(exp_q[0]));
                    chk("rand in_ready low while out_valid", 32'(in_ready), 0);
                    if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                end
                tick();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
                if (out_valid) begin
                    chk("rand drain out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                tick();
            end
            chk("rand scoreboard empty", exp_q.size(), 0);
            chk("rand some accepts", 32'(n_acc > 100), 1);
            fwd = 1'b0;
            tick();
        end

        // Backpressure: DONE held with stable data, extra input ignored
        begin
            int k;
            int bad;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'h7C;
            tick();
            in_valid  = 1'b0;
            k = 0;
            while (!out_valid && k < 20) begin
                tick();
                k++;
            end
            chk("bp latency", k, 7);
            bad = 0;
            for (int c = 0; c < 20; c++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom_range(0, 255));
                tick();
                if (out_valid !== 1'b1 || out_data !== 8'h01 || in_ready !== 1'b0) bad++;
            end
            chk("bp held cycles bad", bad, 0);
            chk("bp out_data", 32'(out_data), 32'h01);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            chk("bp release in_ready", 32'(in_ready), 1);
            chk("bp release out_valid", 32'(out_valid), 0);
            seen_valid = 1'b0;
            repeat (10) begin
                tick();
                if (out_valid) seen_valid = 1'b1;
            end
            chk("bp ignored input not processed", 32'(seen_valid), 0);
        end

        // Reset mid-CALC aborts the result
        in_valid = 1'b1;
        in_data  = 8'hED;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("midrst in CALC", 32'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", 32'(in_ready), 1);
        chk("midrst out_valid", 32'(out_valid), 0);
        chk("midrst out_data", 32'(out_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midrst no result", 32'(seen_valid), 0);
        run_one("after reset", 8'h16, 1'b0, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_sbox_iter.md
# inv_sbox_iter

Iterative AES inverse S-box engine: applies the AES inverse affine transform (matrix inverse of the forward transform, constant 0x05) to an input byte, then computes its GF(2^8) multiplicative inverse as x^254 by repeated square-and-multiply over 7 cycles. It sits on the decryption path of the AES core as an area-lean replacement for a 256-entry inverse S-box ROM, with valid/ready handshakes on both sides.

## Interface
- No parameters; field polynomial fixed at x^8+x^4+x^3+x+1 (0x11B).
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  engine can accept a byte (high only in IDLE)
- in_data  input  8  byte to substitute
- fwd  input  1  present only with INV_SBOX_FWD_EN; sampled on accept; 1 = forward S-box
- out_valid  output  1  out_data valid; held until consumed
- out_ready  input  1  downstream accepts out_data
- out_data  output  8  substituted byte; registered

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- Inverse affine (combinational on in_data): b[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8] ^ c[i], c = 0x05.
- IDLE: in_ready=1. On in_valid&in_ready: x = inv_affine(in_data); acc←0x01, sq←x·x, cnt←0; go CALC.
- CALC: each cycle acc←acc·sq, sq←sq·sq, cnt←cnt+1 (3-bit). When cnt==6 at the update edge: out_data←acc·sq (= x^254), go DONE.
- GF multiply: single-cycle combinational, reduction mod 0x11B; squaring may share the multiplier or use a dedicated squarer.
- Zero input to the inversion gives 0 naturally (0^254 = 0); no special case.
- DONE: out_valid=1, out_data stable. On out_valid&out_ready → IDLE. out_ready ignored in other states.
- in_valid while not in IDLE is ignored; in_data may change freely.
- Reset asserted mid-operation: immediate abort, no output produced, all state cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0x00; internal acc/sq/cnt=0.
- Accept at edge N → CALC during N+1..N+7 → out_valid high after edge N+7 (latency 7 cycles).
- in_ready drops after edge N and stays low through CALC and DONE.
- With out_ready constantly high: consumed at edge N+8, IDLE after N+8, next accept at N+9 earliest; sustained throughput 1 byte / 9 cycles.
- Backpressure: DONE persists indefinitely with out_data and out_valid unchanged.
- No combinational path from any input to any output except none: in_ready, out_valid, out_data are state-derived.

## Configuration
- INV_SBOX_FWD_EN defined: fwd port exists and is latched on accept. fwd=1: inverse affine skipped (x=in_data), and out_data = affine(x^254) with forward affine constant 0x63 applied before the DONE register; fwd=0: inverse S-box as above. Latency unchanged.
- Undefined: no fwd port; block is inverse S-box only.

## Test plan
- Reset: hold rst_n low, check in_ready=1, out_valid=0, out_data=0x00; release, no spurious out_valid.
- Known vectors, out_ready=1: 0x63→0x52... correction per InvSbox: 0x63→0x00, 0x7C→0x01, 0x00→0x52, 0x16→0xFF, 0xED→0x53; out_valid exactly 7 cycles after each accept.
- Exhaustive 0x00–0xFF back-to-back with out_ready=1: each result equals the InvSbox model; accepts spaced exactly 9 cycles.
- Backpressure: send 0x7C, hold out_ready=0 for 20 cycles: out_valid=1, out_data=0x01 stable, in_ready=0, extra in_valid ignored; raise out_ready → IDLE next cycle.
- Reset mid-CALC (3 cycles after accepting 0xED): outputs return to reset values, no result emitted; next byte 0x16 yields 0xFF.
- With INV_SBOX_FWD_EN: fwd=1, in 0x00→0x63, 0x01→0x7C, 0x53→0xED; fwd=0 matches inverse vectors.
